// File: rtl/receive.sv
// rtl/receive.sv - 8N1 UART receiver with 2-flop synchroniser, mid-bit sampling and connection gating
module receive #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       connection_status,
  output logic [7:0] word,
  output logic       word_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    word_q, word_d;
  logic          word_valid_q, word_valid_d;
  logic          frame_error_q, frame_error_d;
  logic          busy_q, busy_d;
  logic          rxd_m_q, rxd_s_q, rxd_p_q;
  logic          fall;

  assign fall = rxd_p_q & ~rxd_s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_m_q <= 1'b1;
      rxd_s_q <= 1'b1;
      rxd_p_q <= 1'b1;
    end else begin
      rxd_m_q <= rxd;
      rxd_s_q <= rxd_m_q;
      rxd_p_q <= rxd_s_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shreg_d       = shreg_q;
    word_d        = word_q;
    word_valid_d  = 1'b0;
    frame_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (connection_status && fall) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = rxd_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          shreg_d = {rxd_s_q, shreg_q[7:1]};
          cnt_d   = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxd_s_q) begin
            word_d       = shreg_q;
            word_valid_d = 1'b1;
          end else begin
            frame_error_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Losing the connection abandons any partial byte silently.
    if (!connection_status) begin
      state_d       = IDLE;
      word_d        = word_q;
      word_valid_d  = 1'b0;
      frame_error_d = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= 3'd0;
      shreg_q       <= 8'h00;
      word_q        <= 8'h00;
      word_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      word_q        <= word_d;
      word_valid_q  <= word_valid_d;
      frame_error_q <= frame_error_d;
      busy_q        <= busy_d;
    end
  end

  assign word        = word_q;
  assign word_valid  = word_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_receive.sv
// tb/tb_receive.sv - directed and randomized frames checked against a frame-timing event model
module tb_receive;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       connection_status = 1'b1;
  logic [7:0] word;
  logic       word_valid;
  logic       frame_error;
  logic       busy;

  typedef struct {
    int         c;
    int         kind;
    logic [7:0] w;
  } ev_t;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;
  ev_t  exp_ev[$];
  ev_t  obs_ev[$];
  int   exp_rise[$], exp_fall[$], obs_rise[$], obs_fall[$];
  logic busy_prev = 1'b0;
  logic [7:0] model_word = 8'h00;
  logic [7:0] b;
  logic       sb;
  logic       prev_bad;
  int   n0, d, r, g, gap;

  receive #(.CLKS_PER_BIT(CPB)) dut (
    .clk               (clk),
    .rst               (rst),
    .rxd               (rxd),
    .connection_status (connection_status),
    .word              (word),
    .word_valid        (word_valid),
    .frame_error       (frame_error),
    .busy              (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every output pulse and every busy transition with the cycle it was seen in.
  always @(negedge clk) begin
    if (word_valid === 1'b1 || frame_error === 1'b1)
      obs_ev.push_back('{c: cyc,
                         kind: (frame_error === 1'b1 ? 2 : 0) + (word_valid === 1'b1 ? 1 : 0),
                         w: word});
    if (busy === 1'b1 && !busy_prev) obs_rise.push_back(cyc);
    if (busy !== 1'b1 && busy_prev) obs_fall.push_back(cyc);
    busy_prev <= (busy === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit, output int start_cyc);
    start_cyc = cyc;
    for (int k = 0; k < 10; k++) begin
      rxd = (k == 0) ? 1'b0 : (k == 9) ? stop_bit : data[k-1];
      tick(CPB);
    end
  endtask

  // Frame outcome from the timing rules: edge seen 2 cycles after the line falls,
  // stop sample at T0 + CPB/2 + 9*CPB, outcome visible the cycle after.
  function automatic void expect_frame(input int start_cyc, input logic [7:0] data, input logic stop_bit);
    int ts;
    ts = start_cyc + 2 + CPB / 2 + 9 * CPB;
    exp_rise.push_back(start_cyc + 3);
    exp_fall.push_back(ts + 1);
    if (stop_bit) begin
      model_word = data;
      exp_ev.push_back('{c: ts + 1, kind: 1, w: data});
    end else begin
      exp_ev.push_back('{c: ts + 1, kind: 2, w: model_word});
    end
  endfunction

  task automatic compare_events(input string tag);
    chk({tag, "_pulse_count"}, obs_ev.size(), exp_ev.size());
    for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++) begin
      chk($sformatf("%s_ev%0d_cycle", tag, i), obs_ev[i].c, exp_ev[i].c);
      chk($sformatf("%s_ev%0d_kind", tag, i), obs_ev[i].kind, exp_ev[i].kind);
      chk($sformatf("%s_ev%0d_word", tag, i), {24'h0, obs_ev[i].w}, {24'h0, exp_ev[i].w});
    end
    chk({tag, "_busy_rise_count"}, obs_rise.size(), exp_rise.size());
    for (int i = 0; i < exp_rise.size() && i < obs_rise.size(); i++)
      chk($sformatf("%s_busy_rise%0d", tag, i), obs_rise[i], exp_rise[i]);
    chk({tag, "_busy_fall_count"}, obs_fall.size(), exp_fall.size());
    for (int i = 0; i < exp_fall.size() && i < obs_fall.size(); i++)
      chk($sformatf("%s_busy_fall%0d", tag, i), obs_fall[i], exp_fall[i]);
    exp_ev.delete();
    obs_ev.delete();
    exp_rise.delete();
    exp_fall.delete();
    obs_rise.delete();
    obs_fall.delete();
  endtask

  initial begin
    rst = 1'b1;
    tick(3);
    chk("reset_word", {24'h0, word}, 32'h0);
    chk("reset_word_valid", {31'h0, word_valid}, 32'h0);
    chk("reset_frame_error", {31'h0, frame_error}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    tick(5);

    send_frame(8'h81, 1'b1, n0);
    expect_frame(n0, 8'h81, 1'b1);
    tick(20);
    compare_events("ideal81");
    chk("ideal81_word", {24'h0, word}, 32'h81);

    send_frame(8'h81, 1'b1, n0);
    expect_frame(n0, 8'h81, 1'b1);
    send_frame(8'h01, 1'b1, n0);
    expect_frame(n0, 8'h01, 1'b1);
    tick(20);
    compare_events("b2b");
    chk("b2b_word", {24'h0, word}, 32'h01);

    rxd = 1'b0;
    g = cyc;
    tick(4);
    rxd = 1'b1;
    exp_rise.push_back(g + 3);
    exp_fall.push_back(g + 11);
    tick(20);
    compare_events("glitch");
    chk("glitch_word", {24'h0, word}, {24'h0, model_word});

    send_frame(8'hA5, 1'b0, n0);
    expect_frame(n0, 8'hA5, 1'b0);
    tick(40);
    rxd = 1'b1;
    tick(10);
    compare_events("frame_err");
    chk("frame_err_word", {24'h0, word}, {24'h0, model_word});

    // Upper nibble all ones keeps the line edge-free once reception is re-enabled.
    b = 8'hF0 | 8'($urandom_range(0, 15));
    fork
      send_frame(b, 1'b1, n0);
      begin
        tick(70);
        connection_status = 1'b0;
        d = cyc;
        tick(20);
        connection_status = 1'b1;
      end
    join
    exp_rise.push_back(n0 + 3);
    exp_fall.push_back(d + 1);
    tick(10);
    send_frame(8'h3C, 1'b1, n0);
    expect_frame(n0, 8'h3C, 1'b1);
    tick(20);
    compare_events("conn_drop");
    chk("conn_drop_word", {24'h0, word}, 32'h3C);

    b = 8'hFC | 8'($urandom_range(0, 3));
    fork
      send_frame(b, 1'b1, n0);
      begin
        tick(50);
        rst = 1'b1;
        r = cyc;
        tick(1);
        rst = 1'b0;
        chk("midreset_word", {24'h0, word}, 32'h0);
        chk("midreset_word_valid", {31'h0, word_valid}, 32'h0);
        chk("midreset_frame_error", {31'h0, frame_error}, 32'h0);
        chk("midreset_busy", {31'h0, busy}, 32'h0);
      end
    join
    exp_rise.push_back(n0 + 3);
    exp_fall.push_back(r + 1);
    model_word = 8'h00;
    tick(10);
    send_frame(8'h55, 1'b1, n0);
    expect_frame(n0, 8'h55, 1'b1);
    tick(20);
    compare_events("after_reset");
    chk("after_reset_word", {24'h0, word}, 32'h55);

    prev_bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      b   = 8'($urandom);
      sb  = ($urandom_range(0, 3) != 0);
      gap = prev_bad ? int'($urandom_range(1, 12)) : int'($urandom_range(0, 12));
      rxd = 1'b1;
      tick(gap);
      send_frame(b, sb, n0);
      expect_frame(n0, b, sb);
      prev_bad = !sb;
    end
    rxd = 1'b1;
    tick(30);
    compare_events("random");
    chk("random_final_word", {24'h0, word}, {24'h0, model_word});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
